car_menu_nav: RTL and testbench

Navigation controller for the car-customisation menu page. Synchronises and debounces the five push-buttons, and runs the menu state machine: row cursor (CHASSIS / WHEELS / CONFIRM), chassis and wheel colour indices, and a confirm flag. Its `arrow_carcolor` output drives the row-cursor input of the car-colour page renderer directly. The colour indices and `menu_done` go to the game core.

---
 rtl/car_menu_nav.sv | 214 +++++++++++++++++++++
 tb/tb_car_menu_nav.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/car_menu_nav.sv
// -----------------------------------------------------------------------------
// car_menu_nav
//
// Navigation controller for the car-customisation menu page. Synchronises
// and debounces the five push-buttons, then runs the menu state machine that
// moves the row cursor, edits the chassis/wheel colour indices and latches
// the confirm flag.
//
// Parameters:
//   DEBOUNCE_CYCLES  consecutive stable samples needed to accept a level change
//   NUM_COLORS       number of selectable colours per item (2..8)
//
// Ports:
//   clock_100mhz       in   system clock
//   reset              in   asynchronous active-high reset
//   enable             in   menu page active (synchronous level)
//   btnU/D/C/L/R       in   raw asynchronous push-buttons, active-high
//   arrow_carcolor     out  row cursor: 00 none, 01 CHASSIS, 10 WHEELS, 11 CONFIRM
//   chassis_color_sel  out  chassis colour index
//   wheel_color_sel    out  wheel colour index
//   menu_done          out  high once CONFIRM has been accepted
//
// state   | meaning
// --------+---------------------------------------------------------------
// IDLE    | page inactive, cursor hidden, waiting for enable
// CHASSIS | cursor on chassis row, L/R edit chassis colour
// WHEELS  | cursor on wheel row, L/R edit wheel colour
// CONFIRM | cursor on confirm row, C accepts the selection
// DONE    | selection accepted, menu_done high, buttons ignored
// -----------------------------------------------------------------------------
module car_menu_nav #(
    parameter int DEBOUNCE_CYCLES = 2_000_000,
    parameter int NUM_COLORS      = 8
) (
    input  logic       clock_100mhz,
    input  logic       reset,
    input  logic       enable,
    input  logic       btnU,
    input  logic       btnD,
    input  logic       btnC,
    input  logic       btnL,
    input  logic       btnR,
    output logic [1:0] arrow_carcolor,
    output logic [2:0] chassis_color_sel,
    output logic [2:0] wheel_color_sel,
    output logic       menu_done
);

    localparam int              CW       = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0]   CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [2:0]      MAX_IDX  = 3'(NUM_COLORS - 1);

    // Button bit positions inside the packed button vectors.
    localparam int B_U = 0;
    localparam int B_D = 1;
    localparam int B_C = 2;
    localparam int B_L = 3;
    localparam int B_R = 4;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        CHASSIS = 3'd1,
        WHEELS  = 3'd2,
        CONFIRM = 3'd3,
        DONE    = 3'd4
    } state_t;

    // -------------------------------------------------------------------------
    // Button front end
    // -------------------------------------------------------------------------
    logic [4:0]    btn_raw;
    logic [4:0]    sync1_q, sync1_d;
    logic [4:0]    sync2_q, sync2_d;
    logic [4:0]    deb_q, deb_d;
    logic [4:0]    deb_dly_q, deb_dly_d;
    logic [4:0]    press_q, press_d;
    logic [CW-1:0] cnt_q [5];
    logic [CW-1:0] cnt_d [5];

    assign btn_raw = {btnR, btnL, btnC, btnD, btnU};

    always_comb begin
        sync1_d   = btn_raw;
        sync2_d   = sync1_q;
        deb_d     = deb_q;
        deb_dly_d = deb_q;
        // Rising edge of the debounced level only; releases give no pulse.
        press_d   = deb_q & ~deb_dly_q;
        for (int i = 0; i < 5; i++) begin
            cnt_d[i] = '0;
            if (sync2_q[i] != deb_q[i]) begin
                if (cnt_q[i] == CNT_LAST) begin
                    deb_d[i] = ~deb_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CW'(1);
                end
            end
        end
    end

    always_ff @(posedge clock_100mhz or posedge reset) begin
        if (reset) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            deb_q     <= '0;
            deb_dly_q <= '0;
            press_q   <= '0;
            for (int i = 0; i < 5; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            deb_q     <= deb_d;
            deb_dly_q <= deb_dly_d;
            press_q   <= press_d;
            for (int i = 0; i < 5; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    // -------------------------------------------------------------------------
    // Menu state machine
    // -------------------------------------------------------------------------
    function automatic logic [2:0] idx_inc(input logic [2:0] v);
        return (v >= MAX_IDX) ? 3'd0 : v + 3'd1;
    endfunction

    function automatic logic [2:0] idx_dec(input logic [2:0] v);
        return (v == 3'd0) ? MAX_IDX : v - 3'd1;
    endfunction

    state_t     state_q, state_d;
    logic [2:0] chassis_q, chassis_d;
    logic [2:0] wheel_q, wheel_d;
    logic [1:0] arrow_q, arrow_d;
    logic       done_q, done_d;

    // Priority C > U > D > L > R is applied only among presses that mean
    // something in the current row, so an inert C in WHEELS does not
    // swallow a simultaneous D.
    always_comb begin
        state_d   = state_q;
        chassis_d = chassis_q;
        wheel_d   = wheel_q;
        case (state_q)
            IDLE: begin
                if (enable) state_d = CHASSIS;
            end
            CHASSIS, WHEELS: begin
                if (!enable) begin
                    state_d = IDLE;
                end else if (press_q[B_U]) begin
                    state_d = (state_q == CHASSIS) ? CONFIRM : CHASSIS;
                end else if (press_q[B_D]) begin
                    state_d = (state_q == CHASSIS) ? WHEELS : CONFIRM;
                end else if (press_q[B_L]) begin
                    if (state_q == CHASSIS) chassis_d = idx_dec(chassis_q);
                    else                    wheel_d   = idx_dec(wheel_q);
                end else if (press_q[B_R]) begin
                    if (state_q == CHASSIS) chassis_d = idx_inc(chassis_q);
                    else                    wheel_d   = idx_inc(wheel_q);
                end
            end
            CONFIRM: begin
                if (!enable) begin
                    state_d = IDLE;
                end else if (press_q[B_C]) begin
                    state_d = DONE;
                end else if (press_q[B_U]) begin
                    state_d = WHEELS;
                end else if (press_q[B_D]) begin
                    state_d = CHASSIS;
                end
            end
            DONE: begin
                if (!enable) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        arrow_d = 2'b00;
        case (state_d)
            CHASSIS: arrow_d = 2'b01;
            WHEELS:  arrow_d = 2'b10;
            CONFIRM: arrow_d = 2'b11;
            default: arrow_d = 2'b00;
        endcase
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clock_100mhz or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            chassis_q <= 3'd0;
            wheel_q   <= 3'd0;
            arrow_q   <= 2'b00;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            chassis_q <= chassis_d;
            wheel_q   <= wheel_d;
            arrow_q   <= arrow_d;
            done_q    <= done_d;
        end
    end

    assign arrow_carcolor    = arrow_q;
    assign chassis_color_sel = chassis_q;
    assign wheel_color_sel   = wheel_q;
    assign menu_done         = done_q;

endmodule

// File: tb/tb_car_menu_nav.sv
// -----------------------------------------------------------------------------
// tb_car_menu_nav
//
// Directed bench for car_menu_nav with DEBOUNCE_CYCLES=4, NUM_COLORS=8.
// Inputs change 1 time unit after a rising edge; outputs are sampled there
// too, so every check sees values settled by the preceding edge.
// -----------------------------------------------------------------------------
module tb_car_menu_nav;

    localparam int DEB = 4;

    logic       clk;
    logic       reset;
    logic       enable;
    logic       btnU, btnD, btnC, btnL, btnR;
    logic [1:0] arrow_carcolor;
    logic [2:0] chassis_color_sel;
    logic [2:0] wheel_color_sel;
    logic       menu_done;

    int checks = 0;
    int errors = 0;

    car_menu_nav #(
        .DEBOUNCE_CYCLES(DEB),
        .NUM_COLORS     (8)
    ) dut (
        .clock_100mhz     (clk),
        .reset            (reset),
        .enable           (enable),
        .btnU             (btnU),
        .btnD             (btnD),
        .btnC             (btnC),
        .btnL             (btnL),
        .btnR             (btnR),
        .arrow_carcolor   (arrow_carcolor),
        .chassis_color_sel(chassis_color_sel),
        .wheel_color_sel  (wheel_color_sel),
        .menu_done        (menu_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // mask bits: 0 U, 1 D, 2 C, 3 L, 4 R. Held for DEB+4 edges so the action
    // has landed, then released and given time for the release to settle.
    task automatic press(input logic [4:0] m);
        {btnR, btnL, btnC, btnD, btnU} = m;
        repeat (DEB + 4) tick();
        {btnR, btnL, btnC, btnD, btnU} = 5'b0;
        repeat (DEB + 4) tick();
    endtask

    initial begin
        reset  = 1'b1;
        enable = 1'b0;
        {btnR, btnL, btnC, btnD, btnU} = 5'b0;
        #2;
        check("rst_arrow",   8'(arrow_carcolor),    8'd0);
        check("rst_chassis", 8'(chassis_color_sel), 8'd0);
        check("rst_wheel",   8'(wheel_color_sel),   8'd0);
        check("rst_done",    8'(menu_done),         8'd0);
        repeat (2) tick();
        reset = 1'b0;
        tick();
        check("idle_arrow", 8'(arrow_carcolor), 8'd0);
        enable = 1'b1;
        check("en_arrow0", 8'(arrow_carcolor), 8'd0);
        tick();
        check("en_arrow1", 8'(arrow_carcolor), 8'd1);

        // 3-cycle glitch on D must be rejected
        btnD = 1'b1;
        repeat (3) tick();
        btnD = 1'b0;
        repeat (10) tick();
        check("glitch_arrow", 8'(arrow_carcolor), 8'd1);

        // held D: first sample at next edge, action on the 8th edge
        btnD = 1'b1;
        repeat (7) tick();
        check("lat_before", 8'(arrow_carcolor), 8'd1);
        tick();
        check("lat_at", 8'(arrow_carcolor), 8'd2);
        repeat (10) tick();
        check("no_repeat", 8'(arrow_carcolor), 8'd2);
        btnD = 1'b0;
        repeat (10) tick();

        // row wrap
        press(5'b00001);
        check("wheels_up", 8'(arrow_carcolor), 8'd1);
        press(5'b00001);
        check("chassis_up_wrap", 8'(arrow_carcolor), 8'd3);
        press(5'b00010);
        check("confirm_down_wrap", 8'(arrow_carcolor), 8'd1);

        // colour wrap
        press(5'b01000);
        check("chassis_l_wrap", 8'(chassis_color_sel), 8'd7);
        press(5'b10000);
        check("chassis_r_wrap", 8'(chassis_color_sel), 8'd0);
        press(5'b10000);
        check("chassis_r", 8'(chassis_color_sel), 8'd1);
        press(5'b00010);
        check("to_wheels", 8'(arrow_carcolor), 8'd2);
        press(5'b10000);
        check("wheel_r", 8'(wheel_color_sel), 8'd1);
        check("chassis_keep", 8'(chassis_color_sel), 8'd1);

        // C+D in WHEELS: only D acts
        press(5'b00110);
        check("cd_arrow", 8'(arrow_carcolor), 8'd3);
        check("cd_done", 8'(menu_done), 8'd0);
        press(5'b00100);
        check("done_flag", 8'(menu_done), 8'd1);
        check("done_arrow", 8'(arrow_carcolor), 8'd0);
        press(5'b00001);
        check("done_ignore", 8'(arrow_carcolor), 8'd0);
        enable = 1'b0;
        tick();
        check("dis_done", 8'(menu_done), 8'd0);
        check("dis_arrow", 8'(arrow_carcolor), 8'd0);
        check("dis_chassis", 8'(chassis_color_sel), 8'd1);
        check("dis_wheel", 8'(wheel_color_sel), 8'd1);

        // L/R inert in CONFIRM
        enable = 1'b1;
        tick();
        check("reen_arrow", 8'(arrow_carcolor), 8'd1);
        press(5'b00010);
        press(5'b00010);
        press(5'b10000);
        check("conf_r_arrow", 8'(arrow_carcolor), 8'd3);
        check("conf_r_chassis", 8'(chassis_color_sel), 8'd1);
        check("conf_r_wheel", 8'(wheel_color_sel), 8'd1);

        // reset in the middle of a debounce count
        btnR = 1'b1;
        repeat (3) tick();
        #2 reset = 1'b1;
        #1;
        check("mid_rst_arrow",   8'(arrow_carcolor),    8'd0);
        check("mid_rst_chassis", 8'(chassis_color_sel), 8'd0);
        check("mid_rst_wheel",   8'(wheel_color_sel),   8'd0);
        check("mid_rst_done",    8'(menu_done),         8'd0);
        tick();
        reset = 1'b0;
        repeat (7) tick();
        check("post_rst_arrow", 8'(arrow_carcolor), 8'd1);
        check("post_rst_wait",  8'(chassis_color_sel), 8'd0);
        tick();
        check("post_rst_press", 8'(chassis_color_sel), 8'd1);
        btnR = 1'b0;
        repeat (DEB + 4) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
